// File: rtl/l1_etiket_denetleyici_pkg.sv
// Shared definitions for the L1 tag controller: request op codes,
// tag-word field positions, FSM state encodings and derived widths.
package l1_etiket_paket;

   localparam int VARSAYILAN_ADRES_BIT     = 32;
   localparam int VARSAYILAN_INDEKS_BIT    = 8;
   localparam int VARSAYILAN_OFSET_BIT     = 4;
   localparam int VARSAYILAN_SRAM_VERI_BIT = 23;

   // Tag field width left over once index and line offset are removed
   localparam int ETIKET_BIT = VARSAYILAN_ADRES_BIT - VARSAYILAN_INDEKS_BIT - VARSAYILAN_OFSET_BIT;

   // Request op codes; the reserved code 2'b11 is handled as a lookup
   localparam logic [1:0] ISTEK_ARA      = 2'b00;
   localparam logic [1:0] ISTEK_DOLDUR   = 2'b01;
   localparam logic [1:0] ISTEK_GECERSIZ = 2'b10;

   // Tag word layout: [19:0] tag, [20] dirty, [21] valid, [22] reserved
   localparam int ETIKET_GECERLI = 21;
   localparam int ETIKET_KIRLI   = 20;

   // Controller FSM states
   localparam logic [1:0] SUPUR = 2'd0;
   localparam logic [1:0] BOSTA = 2'd1;
   localparam logic [1:0] OKU   = 2'd2;
   localparam logic [1:0] SONUC = 2'd3;

endpackage

// File: rtl/l1_etiket_karsilastirici.sv
// Combinational tag compare: decodes a stored tag word against the
// requesting tag and exposes hit, dirty, valid and the victim tag.
module l1_etiket_karsilastirici
   import l1_etiket_paket::*;
#(
   parameter int ET_BIT   = ETIKET_BIT,
   parameter int VERI_BIT = VARSAYILAN_SRAM_VERI_BIT
) (
   input  logic [VERI_BIT-1:0] sram_kelime_i,
   input  logic [ET_BIT-1:0]   istek_etiket_i,
   output logic                isabet_o,
   output logic                kirli_o,
   output logic                gecerli_o,
   output logic [ET_BIT-1:0]   kurban_etiket_o
);

   // The reserved top bit carries no meaning on read
   logic unused_ayrilmis;
   assign unused_ayrilmis = ^sram_kelime_i[VERI_BIT-1:ETIKET_GECERLI+1];

   // Dirty is only meaningful for a valid line, so it is masked by valid
   always_comb begin
      gecerli_o       = sram_kelime_i[ETIKET_GECERLI];
      kirli_o         = sram_kelime_i[ETIKET_GECERLI] & sram_kelime_i[ETIKET_KIRLI];
      kurban_etiket_o = sram_kelime_i[ET_BIT-1:0];
      isabet_o        = sram_kelime_i[ETIKET_GECERLI] && (sram_kelime_i[ET_BIT-1:0] == istek_etiket_i);
   end

endmodule

// File: rtl/sram_l1etiket.sv
// Behavioural model of the 256 x 23b single-port tag SRAM: port inputs are
// captured at posedge, the array is read or written at the following negedge.
module sram_l1etiket (
   input  logic        clk0,
   input  logic        csb0,
   input  logic        web0,
   input  logic [7:0]  addr0,
   input  logic [22:0] din0,
   output logic [22:0] dout0
);

   logic [22:0] bellek [256];
   logic        csb_r;
   logic        web_r;
   logic [7:0]  addr_r;
   logic [22:0] din_r;

   // Capture the port at the rising edge
   always_ff @(posedge clk0) begin
      csb_r  <= csb0;
      web_r  <= web0;
      addr_r <= addr0;
      din_r  <= din0;
   end

   // Commit a captured write at the falling edge
   always_ff @(negedge clk0) begin
      if (!csb_r && !web_r) bellek[addr_r] <= din_r;
   end

   // Present a captured read at the falling edge
   always_ff @(negedge clk0) begin
      if (!csb_r && web_r) dout0 <= bellek[addr_r];
   end

endmodule

// File: rtl/l1_etiket_denetleyici.sv
// Request-side controller for the L1 tag SRAM: sweeps the array after reset
// or flush, serves fill/invalidate writes, and turns lookups into a
// hit/dirty/victim result on a valid/ready channel.
module l1_etiket_denetleyici
   import l1_etiket_paket::*;
#(
   parameter int ADRES_BIT     = VARSAYILAN_ADRES_BIT,
   parameter int INDEKS_BIT    = VARSAYILAN_INDEKS_BIT,
   parameter int OFSET_BIT     = VARSAYILAN_OFSET_BIT,
   parameter int SRAM_VERI_BIT = VARSAYILAN_SRAM_VERI_BIT
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     temizle_i,
   output logic                     mesgul_o,
   input  logic                     istek_gecerli_i,
   output logic                     istek_hazir_o,
   input  logic [1:0]               istek_tip_i,
   input  logic [ADRES_BIT-1:0]     istek_adres_i,
   input  logic                     istek_kirli_i,
   output logic                     sonuc_gecerli_o,
   input  logic                     sonuc_hazir_i,
   output logic                     sonuc_isabet_o,
   output logic                     sonuc_kirli_o,
   output logic                     sonuc_satir_gecerli_o,
   output logic [ADRES_BIT-1:0]     sonuc_kurban_adres_o,
   output logic                     sram_csb_o,
   output logic                     sram_web_o,
   output logic [INDEKS_BIT-1:0]    sram_addr_o,
   output logic [SRAM_VERI_BIT-1:0] sram_din_o,
   input  logic [SRAM_VERI_BIT-1:0] sram_dout_i
);

   localparam int ET_BIT = ADRES_BIT - INDEKS_BIT - OFSET_BIT;

   logic [1:0]            durum, sonraki;
   logic [INDEKS_BIT-1:0] sayac;
   logic                  temizle_bekle;
   logic                  kabul, ara_kabul;
   logic [ET_BIT-1:0]     istek_etiket;
   logic [INDEKS_BIT-1:0] istek_indeks;
   logic                  unused_ofset;

   logic [ET_BIT-1:0]     etiket_p0;
   logic [INDEKS_BIT-1:0] indeks_p0;

   logic                  k_isabet, k_kirli, k_gecerli;
   logic [ET_BIT-1:0]     k_kurban_etiket;

   logic                  isabet_p1, kirli_p1, gecerli_p1;
   logic [ADRES_BIT-1:0]  kurban_p1;

   assign istek_etiket = istek_adres_i[ADRES_BIT-1 -: ET_BIT];
   assign istek_indeks = istek_adres_i[OFSET_BIT +: INDEKS_BIT];
   assign unused_ofset = ^istek_adres_i[OFSET_BIT-1:0];

   assign istek_hazir_o = (durum == BOSTA) && !temizle_i;
   assign kabul         = istek_hazir_o && istek_gecerli_i;
   assign ara_kabul     = kabul && (istek_tip_i != ISTEK_DOLDUR) && (istek_tip_i != ISTEK_GECERSIZ);

   l1_etiket_karsilastirici #(
      .ET_BIT   (ET_BIT),
      .VERI_BIT (SRAM_VERI_BIT)
   ) u_karsilastirici (
      .sram_kelime_i   (sram_dout_i),
      .istek_etiket_i  (etiket_p0),
      .isabet_o        (k_isabet),
      .kirli_o         (k_kirli),
      .gecerli_o       (k_gecerli),
      .kurban_etiket_o (k_kurban_etiket)
   );

   // State register; reset always lands in the sweep
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) durum <= SUPUR;
      else         durum <= sonraki;
   end

   // Next-state: a flush seen mid-lookup waits for the result handshake
   always_comb begin
      sonraki = durum;
      case (durum)
         SUPUR: if (!temizle_i && (sayac == {INDEKS_BIT{1'b1}})) sonraki = BOSTA;
         BOSTA: begin
            if (temizle_i)      sonraki = SUPUR;
            else if (ara_kabul) sonraki = OKU;
         end
         OKU:   sonraki = SONUC;
         SONUC: if (sonuc_hazir_i) sonraki = (temizle_bekle || temizle_i) ? SUPUR : BOSTA;
         default: sonraki = SUPUR;
      endcase
   end

   // Outputs: SRAM port is driven combinationally by sweep or accepted request
   always_comb begin
      mesgul_o        = (durum == SUPUR);
      sonuc_gecerli_o = (durum == SONUC);
      sram_csb_o      = 1'b1;
      sram_web_o      = 1'b1;
      sram_addr_o     = '0;
      sram_din_o      = '0;
      if ((durum == SUPUR) && rstn_i) begin
         sram_csb_o  = 1'b0;
         sram_web_o  = 1'b0;
         sram_addr_o = sayac;
      end else if (kabul) begin
         sram_csb_o  = 1'b0;
         sram_addr_o = istek_indeks;
         if (!ara_kabul) begin
            sram_web_o = 1'b0;
            if (istek_tip_i == ISTEK_DOLDUR) begin
               sram_din_o[ETIKET_GECERLI] = 1'b1;
               sram_din_o[ETIKET_KIRLI]   = istek_kirli_i;
               sram_din_o[ET_BIT-1:0]     = istek_etiket;
            end
         end
      end
   end

   // Sweep counter and latched flush request
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sayac         <= '0;
         temizle_bekle <= 1'b0;
      end else begin
         if ((durum == SUPUR) && !temizle_i) sayac <= sayac + 1'b1;
         else                                sayac <= '0;
         if (sonraki == SUPUR)                                     temizle_bekle <= 1'b0;
         else if (temizle_i && ((durum == OKU) || (durum == SONUC))) temizle_bekle <= 1'b1;
      end
   end

   // ---- p0: capture lookup tag/index at accept ----
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         etiket_p0 <= '0;
         indeks_p0 <= '0;
      end else if (ara_kabul) begin
         etiket_p0 <= istek_etiket;
         indeks_p0 <= istek_indeks;
      end
   end

   // ---- p1: register compare result while the SRAM word is valid ----
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         isabet_p1  <= 1'b0;
         kirli_p1   <= 1'b0;
         gecerli_p1 <= 1'b0;
         kurban_p1  <= '0;
      end else if (durum == OKU) begin
         isabet_p1  <= k_isabet;
         kirli_p1   <= k_kirli;
         gecerli_p1 <= k_gecerli;
         kurban_p1  <= {k_kurban_etiket, indeks_p0, {OFSET_BIT{1'b0}}};
      end
   end

   assign sonuc_isabet_o        = isabet_p1;
   assign sonuc_kirli_o         = kirli_p1;
   assign sonuc_satir_gecerli_o = gecerli_p1;
   assign sonuc_kurban_adres_o  = kurban_p1;

endmodule
